// File: rtl/cc_pkg.sv
// Shared definitions for the CC job arbiter: widths, opt bit positions and FSM states.
package cc_pkg;

    localparam int DATA_W = 4;
    localparam int OPT_W  = 4;
    localparam int OUT_W  = 9;
    localparam int CNT_W  = 8;

    // Bit positions inside the opt field understood by the CC datapath.
    localparam int OPT_SORT = 0;
    localparam int OPT_ASC  = 1;
    localparam int OPT_MEAN = 2;
    localparam int OPT_MUL  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The requester that did not win last time takes a tie;
// the history register moves only when a grant is actually accepted.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic grant_o,
    output logic grant_valid_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick the lone requester, or on a tie the one that was not served last.
    always_comb begin
        grant_valid_o = valid0_i | valid1_i;
        grant_o       = (valid0_i & valid1_i) ? ~last_grant_q : valid1_i;
        last_grant_d  = accept_i ? grant_o : last_grant_q;
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/cc_job_arbiter.sv
// Shares one combinational CC unit between two requesters: accept a job, present it to
// the CC for one cycle from registers, capture the result and hand it back tagged with
// the requester id. Single-entry: nothing new is accepted until the response is taken.
module cc_job_arbiter #(
    parameter int DATA_W = cc_pkg::DATA_W,
    parameter int OPT_W  = cc_pkg::OPT_W,
    parameter int OUT_W  = cc_pkg::OUT_W,
    parameter int CNT_W  = cc_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [4*DATA_W-1:0] req0_data,
    input  logic [OPT_W-1:0]    req0_opt,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [4*DATA_W-1:0] req1_data,
    input  logic [OPT_W-1:0]    req1_opt,
    output logic [DATA_W-1:0]   cc_in_n0,
    output logic [DATA_W-1:0]   cc_in_n1,
    output logic [DATA_W-1:0]   cc_in_n2,
    output logic [DATA_W-1:0]   cc_in_n3,
    output logic [OPT_W-1:0]    cc_opt,
    input  logic [OUT_W-1:0]    cc_out_n,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OUT_W-1:0]    rsp_data,
    output logic                rsp_id,
    output logic                busy,
    output logic [CNT_W-1:0]    jobs_done
);

    import cc_pkg::*;

    state_e              state_q,     state_d;
    logic [4*DATA_W-1:0] job_data_q,  job_data_d;
    logic [OPT_W-1:0]    job_opt_q,   job_opt_d;
    logic                job_id_q,    job_id_d;
    logic [OUT_W-1:0]    rsp_data_q,  rsp_data_d;
    logic [CNT_W-1:0]    jobs_done_q, jobs_done_d;

    logic grant;
    logic grant_valid;
    logic accept;
    logic in_idle;

    rr_arb2 u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid0_i      (req0_valid),
        .valid1_i      (req1_valid),
        .accept_i      (accept),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // Ready only for the granted requester while idle; forced low while reset is held.
    assign in_idle    = (state_q == IDLE);
    assign req0_ready = rst_n & in_idle & grant_valid & ~grant;
    assign req1_ready = rst_n & in_idle & grant_valid &  grant;
    assign accept     = req0_ready | req1_ready;

    // CC operands come straight from the job registers so they are stable for the whole
    // EXEC cycle and keep the last job's values while idle.
    logic [DATA_W-1:0] operand [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_operand
        assign operand[gi] = job_data_q[gi*DATA_W +: DATA_W];
    end

    assign cc_in_n0  = operand[0];
    assign cc_in_n1  = operand[1];
    assign cc_in_n2  = operand[2];
    assign cc_in_n3  = operand[3];
    assign cc_opt    = job_opt_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = job_id_q;
    assign busy      = ~in_idle;
    assign jobs_done = jobs_done_q;

    // Job sequencing: IDLE accepts, EXEC samples the CC result, RESP waits for the consumer.
    always_comb begin
        state_d     = state_q;
        job_data_d  = job_data_q;
        job_opt_d   = job_opt_q;
        job_id_d    = job_id_q;
        rsp_data_d  = rsp_data_q;
        jobs_done_d = jobs_done_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    job_data_d = grant ? req1_data : req0_data;
                    job_opt_d  = grant ? req1_opt  : req0_opt;
                    job_id_d   = grant;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = cc_out_n;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    jobs_done_d = jobs_done_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            job_data_q  <= '0;
            job_opt_q   <= '0;
            job_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            job_data_q  <= job_data_d;
            job_opt_q   <= job_opt_d;
            job_id_q    <= job_id_d;
            rsp_data_q  <= rsp_data_d;
            jobs_done_q <= jobs_done_d;
        end
    end

endmodule

// File: tb/tb_cc_job_arbiter.sv
// Directed bench for cc_job_arbiter with a small CC stand-in driving cc_out_n.
module tb_cc_job_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_data;
    logic [3:0]  req0_opt;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_data;
    logic [3:0]  req1_opt;
    logic [3:0]  cc_in_n0, cc_in_n1, cc_in_n2, cc_in_n3;
    logic [3:0]  cc_opt;
    logic [8:0]  cc_out_n;
    logic        rsp_valid, rsp_ready;
    logic [8:0]  rsp_data;
    logic        rsp_id;
    logic        busy;
    logic [7:0]  jobs_done;

    int tests_run;
    int tests_failed;

    cc_job_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_opt   (req0_opt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_opt   (req1_opt),
        .cc_in_n0   (cc_in_n0),
        .cc_in_n1   (cc_in_n1),
        .cc_in_n2   (cc_in_n2),
        .cc_in_n3   (cc_in_n3),
        .cc_opt     (cc_opt),
        .cc_out_n   (cc_out_n),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CC stand-in covering the two modes used here: MUL gives 2*n1*n0+n3, otherwise the sum.
    function automatic logic [8:0] cc_model(input logic [3:0] a0, input logic [3:0] a1,
                                            input logic [3:0] a2, input logic [3:0] a3,
                                            input logic [3:0] op);
        int s0, s1, s2, s3, r;
        s0 = $signed(a0);
        s1 = $signed(a1);
        s2 = $signed(a2);
        s3 = $signed(a3);
        if (op[3]) r = 2 * s1 * s0 + s3;
        else       r = s0 + s1 + s2 + s3;
        return r[8:0];
    endfunction

    assign cc_out_n = cc_model(cc_in_n0, cc_in_n1, cc_in_n2, cc_in_n3, cc_opt);

    task automatic test_reset();
        rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 16'hFFFF; req1_data = 16'hFFFF; req0_opt = 4'hF; req1_opt = 4'hF;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/rsp_valid/rdy0/rdy1 got %b expected 0000",
                     {busy, rsp_valid, req0_ready, req1_ready});
        end
        tests_run++;
        if ({cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_cc: got %h expected 00000",
                     {cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt});
        end
        tests_run++;
        if ({rsp_data, rsp_id, jobs_done} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_rsp: data=%h id=%b jobs=%0d expected all 0", rsp_data, rsp_id, jobs_done);
        end
        $display("[TB] reset: outputs checked with rst_n low");
        repeat (2) @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_req0();
        @(negedge clk);
        req0_data = 16'h4321; req0_opt = 4'b0000; req0_valid = 1'b1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL s0_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        tests_run++;
        if ({busy, rsp_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL s0_exec: busy/rsp_valid got %b expected 10", {busy, rsp_valid});
        end
        tests_run++;
        if ({cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt} !== 20'h43210) begin
            tests_failed++;
            $display("FAIL s0_cc_drive: got %h expected 43210",
                     {cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 9'd10}) begin
            tests_failed++;
            $display("FAIL s0_rsp: valid=%b id=%b data=%0d expected 1/0/10", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if ({busy, rsp_valid, jobs_done} !== {2'b00, 8'd1}) begin
            tests_failed++;
            $display("FAIL s0_done: busy=%b valid=%b jobs=%0d expected 0/0/1", busy, rsp_valid, jobs_done);
        end
        tests_run++;
        if ({cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt} !== 20'h43210) begin
            tests_failed++;
            $display("FAIL s0_cc_hold: got %h expected 43210",
                     {cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt});
        end
        $display("[TB] single req0: data=%0d id=%0d jobs=%0d", rsp_data, rsp_id, jobs_done);
    endtask

    task automatic test_single_req1();
        @(negedge clk);
        req1_data = 16'h4321; req1_opt = 4'b1000; req1_valid = 1'b1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL s1_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 9'd8}) begin
            tests_failed++;
            $display("FAIL s1_rsp: valid=%b id=%b data=%0d expected 1/1/8", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if (jobs_done !== 8'd2) begin
            tests_failed++;
            $display("FAIL s1_jobs: got %0d expected 2", jobs_done);
        end
        $display("[TB] single req1: id=%0d jobs=%0d", rsp_id, jobs_done);
    endtask

    task automatic test_back_to_back();
        int         acc_cyc[$];
        logic       ids[$];
        logic [8:0] datas[$];
        int         exp_cyc[4];
        logic       exp_id[4];
        logic [8:0] exp_data[4];
        exp_cyc  = '{0, 3, 6, 9};
        exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_data = '{9'd7, 9'h1FA, 9'd7, 9'h1FA};
        @(negedge clk);
        req0_data = 16'h15E3; req0_opt = 4'b0000; req0_valid = 1'b1;
        req1_data = 16'h64D2; req1_opt = 4'b1000; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (req0_ready | req1_ready) acc_cyc.push_back(i);
            if (rsp_valid) begin
                ids.push_back(rsp_id);
                datas.push_back(rsp_data);
            end
            if (i == 11) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b0;
        tests_run++;
        if (acc_cyc.size() != 4 || ids.size() != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d expected 4/4", acc_cyc.size(), ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (acc_cyc[k] != exp_cyc[k] || ids[k] !== exp_id[k] || datas[k] !== exp_data[k]) begin
                    tests_failed++;
                    $display("FAIL b2b_job%0d: cyc=%0d id=%b data=%h expected cyc=%0d id=%b data=%h",
                             k, acc_cyc[k], ids[k], datas[k], exp_cyc[k], exp_id[k], exp_data[k]);
                end
                $display("[TB] back-to-back job %0d: id=%0d data=%h", k, ids[k], datas[k]);
            end
        end
        tests_run++;
        if (jobs_done !== 8'd6) begin
            tests_failed++;
            $display("FAIL b2b_jobs: got %0d expected 6", jobs_done);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        req0_data = 16'h4321; req0_opt = 4'b0000; req0_valid = 1'b1;
        @(posedge clk); #1;
        req1_data = 16'h4321; req1_opt = 4'b1000; req1_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if ({rsp_valid, req0_ready, req1_ready} !== 3'b100 || rsp_data !== 9'd10) begin
                tests_failed++;
                $display("FAIL stall_cyc%0d: valid/rdy0/rdy1=%b data=%0d expected 100/10",
                         k, {rsp_valid, req0_ready, req1_ready}, rsp_data);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b01 || jobs_done !== 8'd7) begin
            tests_failed++;
            $display("FAIL stall_release: rdy=%b jobs=%0d expected 01/7", {req0_ready, req1_ready}, jobs_done);
        end
        req0_valid = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 9'd8}) begin
            tests_failed++;
            $display("FAIL stall_next: valid=%b id=%b data=%0d expected 1/1/8", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("[TB] stall: released after 5 cycles, jobs=%0d", jobs_done);
    endtask

    task automatic test_negative();
        @(negedge clk);
        req0_data = 16'hF078; req0_opt = 4'b1000; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 9'h18F}) begin
            tests_failed++;
            $display("FAIL neg_rsp: valid=%b id=%b data=%h expected 1/0/18f (-113)", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if (jobs_done !== 8'd9) begin
            tests_failed++;
            $display("FAIL neg_jobs: got %0d expected 9", jobs_done);
        end
        $display("[TB] negative: data=%0d jobs=%0d", $signed(rsp_data), jobs_done);
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        req0_data = 16'h7777; req0_opt = 4'b0000; req0_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, rsp_valid, req0_ready, req1_ready, jobs_done} !== 12'h0) begin
            tests_failed++;
            $display("FAIL rst_exec_ctrl: busy/valid/rdy=%b jobs=%0d expected 0000/0",
                     {busy, rsp_valid, req0_ready, req1_ready}, jobs_done);
        end
        tests_run++;
        if ({cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt} !== 20'h0) begin
            tests_failed++;
            $display("FAIL rst_exec_cc: got %h expected 00000",
                     {cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0, cc_opt});
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_exec_norsp%0d: rsp_valid got %b expected 0", k, rsp_valid);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        req1_data = 16'h4321; req1_opt = 4'b0000; req1_valid = 1'b1;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_after_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 9'd10}) begin
            tests_failed++;
            $display("FAIL rst_after_rsp: valid=%b id=%b data=%0d expected 1/1/10", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if (jobs_done !== 8'd1) begin
            tests_failed++;
            $display("FAIL rst_after_jobs: got %0d expected 1", jobs_done);
        end
        $display("[TB] reset mid-EXEC then req1 job: jobs=%0d", jobs_done);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_req0();
        test_single_req1();
        test_back_to_back();
        test_stall();
        test_negative();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cc_job_arbiter.md
Name: cc_job_arbiter

Overview:
- Shares one combinational CC compute unit between two requesters.
- Each requester submits a job (four signed 4-bit operands plus a 4-bit opt) over a valid/ready handshake.
- A round-robin arbiter picks one job, the block drives the CC ports from registered operands, captures the 9-bit signed result, and returns it on a single response channel tagged with the requester id.
- Sits between the host-side request logic and the CC datapath instance.

Parameters:
- DATA_W, 4, width of each signed operand
- OPT_W, 4, width of the opt control field
- OUT_W, 9, width of the signed CC result
- CNT_W, 8, width of the completed-job counter

Ports:
- clk  in  1  single system clock; all flops on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_data  in  4*DATA_W  operands: [3:0]=n0, [7:4]=n1, [11:8]=n2, [15:12]=n3
- req0_opt  in  OPT_W  opt for requester 0 job
- req1_valid, req1_ready, req1_data, req1_opt: same as requester 0, for requester 1
- cc_in_n0..cc_in_n3  out  DATA_W each  operands driven to CC
- cc_opt  out  OPT_W  opt driven to CC
- cc_out_n  in  OUT_W  signed CC result (combinational from cc_* outputs)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  OUT_W  captured signed result
- rsp_id  out  1  requester id of the result
- busy  out  1  high in any state other than IDLE
- jobs_done  out  CNT_W  completed-response count; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - All operand and opt registers, cc_* outputs, rsp_data, rsp_id and jobs_done are 0.
  - rsp_valid=0, busy=0, both req*_ready=0.
- States are IDLE, EXEC and RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the one not equal to last_grant.
  - reqN_ready is combinational: 1 only for the granted requester, only in IDLE with reqN_valid=1.
  - On the handshake: latch data, opt and id into the job registers, set last_grant=N, go to EXEC.
  - No valid requester: stay in IDLE; registers hold.
- EXEC (exactly 1 cycle):
  - cc_* outputs are driven directly from the job registers, so they are glitch-free and stable the whole cycle.
  - At the end of the cycle, capture cc_out_n into rsp_data, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable until rsp_ready=1.
  - On the handshake: jobs_done+1, go to IDLE.
  - A new request cannot be accepted in the same cycle; the block is a single-entry buffer.
- Latency: accept edge at T, rsp_valid high from T+2. Back-to-back throughput is 1 job per 3 cycles when rsp_ready is held at 1.
- cc_* outputs keep the last job's values while idle; they do not return to 0 between jobs.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1. A requester dropping valid does not reset last_grant.
- Width rules: result is passed through unmodified, sign preserved; no rescaling or saturation in this block.
- Response stall: rsp_ready held low stalls in RESP indefinitely; both req*_ready stay 0.
- Valid withdrawn before grant: no effect, since no ready was issued.
- Reset mid-EXEC or mid-RESP: the job is discarded, no response is produced, jobs_done returns to 0.

Decomposition:
- Shared package cc_pkg holds:
  - state enum {IDLE, EXEC, RESP}
  - DATA_W, OPT_W, OUT_W
  - opt bit-position constants: OPT_SORT=0, OPT_ASC=1, OPT_MEAN=2, OPT_MUL=3
- Sub-module rr_arb2: 2-way round-robin grant with last_grant register; it updates only on the accept strobe.

Test Plan:
- Single job, req0: n0..n3=1,2,3,4, opt=4'b0000 -> req0_ready at T, rsp_valid at T+2, rsp_data=10, rsp_id=0, jobs_done=1.
- Single job, req1: n0..n3=1,2,3,4, opt=4'b1000 -> rsp_data=8, rsp_id=1.
- Both requesters valid for 4 jobs, rsp_ready=1 -> rsp_id sequence 0,1,0,1. Jobs accepted every 3 cycles; each rsp_data matches the CC model.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_data stable, both req*_ready=0 throughout. Acceptance on release -> next job granted 1 cycle later.
- Negative result: req0 n0..n3=-8,7,0,-1, opt=4'b1000 -> rsp_data=2*7*(-8)+(-1)=-113, sign correct in 9 bits.
- Assert rst_n=0 during EXEC -> all outputs at reset values asynchronously, no response issued. After release, a req1-only job completes normally with jobs_done=1.
